// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO with any DEPTH >= 2 (not only
// powers of two), programmable almost-full/almost-empty thresholds,
// registered or first-word-fall-through read data, and one-cycle
// overflow/underflow pulses for rejected requests.
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = 60,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  // Pointer width; guarded so a bad DEPTH reaches the parameter check below
  // instead of failing on a zero-width vector first.
  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  if (DEPTH < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("param_fifo: need DEPTH >= 2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;

  // Requests are qualified only by the current registered flags, so a write
  // at full is rejected even if a read frees a slot the same cycle, and a
  // read at empty never sees the word being written (no bypass).
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Status flags decode straight from the registered occupancy.
  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign almost_full  = (count >= CW'(AF_LEVEL));

  // Storage is deliberately not reset; stale words are unreachable because
  // reset clears both pointers and the occupancy.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy and the rejected-request pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is visible without a read; forced to zero while empty so the
    // output never shows stale storage.
    assign data_out = empty ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;

    // Registered read data: loads the popped word, holds otherwise.
    always_ff @(posedge clk) begin
      if (!rst)        dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr];
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed checks of param_fifo in three configurations that
// share one stimulus bus: defaults (A), DEPTH=5/AF=4/AE=1 (B), FWFT=1 (C).
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  logic       c_empty, c_full, c_ae, c_af, c_ovf, c_unf;
  logic [6:0] a_count, c_count;
  logic [2:0] b_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_fifo u_a (
    .clk(clk), .rst(rst), .wr_en(wr), .rd_en(rd), .data_in(din),
    .data_out(a_dout), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf)
  );

  param_fifo #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr), .rd_en(rd), .data_in(din),
    .data_out(b_dout), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf)
  );

  param_fifo #(.FWFT(1)) u_c (
    .clk(clk), .rst(rst), .wr_en(wr), .rd_en(rd), .data_in(din),
    .data_out(c_dout), .empty(c_empty), .full(c_full),
    .almost_empty(c_ae), .almost_full(c_af), .count(c_count),
    .overflow(c_ovf), .underflow(c_unf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Occupancy plus the four flags, expected flags derived from the expected count.
  task automatic chk_occ(input string nm, input int cnt, input int e, input int f,
                         input int ae, input int af, input int exp_cnt,
                         input int depth, input int ae_lvl, input int af_lvl);
    chk({nm, ".count"}, cnt, exp_cnt);
    chk({nm, ".empty"}, e, int'(exp_cnt == 0));
    chk({nm, ".full"},  f, int'(exp_cnt == depth));
    chk({nm, ".ae"},    ae, int'(exp_cnt <= ae_lvl));
    chk({nm, ".af"},    af, int'(exp_cnt >= af_lvl));
  endtask

  // One clock: drive at negedge, sample 1ns after the rising edge, then idle.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    @(negedge clk);
    wr = w; rd = r; din = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  // Reset cycle with both requests asserted to show reset overrides them.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; wr = 1'b1; rd = 1'b1; din = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
  endtask

  typedef struct {
    logic       wr, rd;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       ovf, unf;
  } vec_t;

  vec_t vt [36];

  initial begin
    // DEPTH=5 sequence: interleaved traffic keeping occupancy 2..4 across
    // pointer wrap, then empty underflow, fill to full, overflow with read,
    // drain, and write+read at empty.
    vt[0]  = '{1'b1, 1'b0, 8'hB1, 1, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 8'hB2, 2, 8'h00, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 8'hB3, 3, 8'h00, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 8'hB4, 4, 8'h00, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 8'hB5, 4, 8'hB1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 8'h00, 3, 8'hB2, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 8'hB6, 4, 8'hB2, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 8'hB7, 4, 8'hB3, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 8'h00, 3, 8'hB4, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 8'h00, 2, 8'hB5, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 8'hB8, 3, 8'hB5, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 8'hB9, 3, 8'hB6, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 8'hBA, 4, 8'hB6, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 8'hBB, 4, 8'hB7, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b1, 8'h00, 3, 8'hB8, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b0, 8'hBC, 4, 8'hB8, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b1, 8'hBD, 4, 8'hB9, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b1, 8'h00, 3, 8'hBA, 1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b1, 8'h00, 2, 8'hBB, 1'b0, 1'b0};
    vt[19] = '{1'b0, 1'b1, 8'h00, 1, 8'hBC, 1'b0, 1'b0};
    vt[20] = '{1'b0, 1'b1, 8'h00, 0, 8'hBD, 1'b0, 1'b0};
    vt[21] = '{1'b0, 1'b1, 8'h00, 0, 8'hBD, 1'b0, 1'b1};
    vt[22] = '{1'b0, 1'b0, 8'h00, 0, 8'hBD, 1'b0, 1'b0};
    vt[23] = '{1'b1, 1'b0, 8'hBE, 1, 8'hBD, 1'b0, 1'b0};
    vt[24] = '{1'b1, 1'b0, 8'hBF, 2, 8'hBD, 1'b0, 1'b0};
    vt[25] = '{1'b1, 1'b0, 8'hC0, 3, 8'hBD, 1'b0, 1'b0};
    vt[26] = '{1'b1, 1'b0, 8'hC1, 4, 8'hBD, 1'b0, 1'b0};
    vt[27] = '{1'b1, 1'b0, 8'hC2, 5, 8'hBD, 1'b0, 1'b0};
    vt[28] = '{1'b1, 1'b1, 8'hC3, 4, 8'hBE, 1'b1, 1'b0};
    vt[29] = '{1'b0, 1'b0, 8'h00, 4, 8'hBE, 1'b0, 1'b0};
    vt[30] = '{1'b0, 1'b1, 8'h00, 3, 8'hBF, 1'b0, 1'b0};
    vt[31] = '{1'b0, 1'b1, 8'h00, 2, 8'hC0, 1'b0, 1'b0};
    vt[32] = '{1'b0, 1'b1, 8'h00, 1, 8'hC1, 1'b0, 1'b0};
    vt[33] = '{1'b0, 1'b1, 8'h00, 0, 8'hC2, 1'b0, 1'b0};
    vt[34] = '{1'b1, 1'b1, 8'hC4, 1, 8'hC2, 1'b0, 1'b1};
    vt[35] = '{1'b0, 1'b1, 8'h00, 0, 8'hC4, 1'b0, 1'b0};

    // ---------------- A: defaults, FWFT=0 ----------------
    repeat (2) @(posedge clk);
    do_reset();
    chk_occ("a.rst", int'(a_count), a_empty, a_full, a_ae, a_af, 0, 64, 4, 60);
    chk("a.rst.dout", a_dout, 8'h00);
    chk("a.rst.ovf", a_ovf, 0);
    chk("a.rst.unf", a_unf, 0);

    step(1'b0, 1'b1, 8'h00);
    chk("a.empty_rd.unf", a_unf, 1);
    chk("a.empty_rd.count", int'(a_count), 0);
    chk("a.empty_rd.dout", a_dout, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("a.empty_rd.unf_drop", a_unf, 0);

    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk_occ($sformatf("a.fill%0d", i), int'(a_count), a_empty, a_full, a_ae, a_af, i, 64, 4, 60);
    end

    step(1'b1, 1'b0, 8'hFF);
    chk("a.ovf.pulse", a_ovf, 1);
    chk("a.ovf.count", int'(a_count), 64);

    step(1'b1, 1'b1, 8'hEE);
    chk("a.full_wr_rd.ovf", a_ovf, 1);
    chk_occ("a.full_wr_rd", int'(a_count), a_empty, a_full, a_ae, a_af, 63, 64, 4, 60);
    chk("a.full_wr_rd.dout", a_dout, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    chk("a.ovf.drop", a_ovf, 0);

    for (int i = 2; i <= 64; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("a.drain%0d", i), a_dout, i);
    end
    chk_occ("a.drained", int'(a_count), a_empty, a_full, a_ae, a_af, 0, 64, 4, 60);

    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h12);
    step(1'b1, 1'b0, 8'h13);
    step(1'b1, 1'b1, 8'h14);
    chk("a.wr_rd_at3.count", int'(a_count), 3);
    chk("a.wr_rd_at3.dout", a_dout, 8'h11);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    chk("a.pre_rst.count", int'(a_count), 10);

    do_reset();
    chk_occ("a.mid_rst", int'(a_count), a_empty, a_full, a_ae, a_af, 0, 64, 4, 60);
    chk("a.mid_rst.dout", a_dout, 8'h00);
    step(1'b1, 1'b0, 8'h77);
    chk("a.post_rst.count", int'(a_count), 1);
    step(1'b0, 1'b1, 8'h00);
    chk("a.post_rst.dout", a_dout, 8'h77);
    chk("a.post_rst.empty", a_empty, 1);

    // ---------------- B: DEPTH=5 table ----------------
    do_reset();
    chk_occ("b.rst", int'(b_count), b_empty, b_full, b_ae, b_af, 0, 5, 1, 4);
    for (int i = 0; i < 36; i++) begin
      step(vt[i].wr, vt[i].rd, vt[i].din);
      chk_occ($sformatf("b.v%0d", i), int'(b_count), b_empty, b_full, b_ae, b_af,
              vt[i].cnt, 5, 1, 4);
      chk($sformatf("b.v%0d.dout", i), b_dout, vt[i].dout);
      chk($sformatf("b.v%0d.ovf", i), b_ovf, vt[i].ovf);
      chk($sformatf("b.v%0d.unf", i), b_unf, vt[i].unf);
    end

    // ---------------- C: FWFT=1 ----------------
    do_reset();
    chk("c.rst.empty", c_empty, 1);
    step(1'b1, 1'b0, 8'hA5);
    chk("c.head.empty", c_empty, 0);
    chk("c.head.dout", c_dout, 8'hA5);
    step(1'b1, 1'b0, 8'h5A);
    chk("c.second.count", int'(c_count), 2);
    chk("c.second.dout", c_dout, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    chk("c.pop.count", int'(c_count), 1);
    chk("c.pop.dout", c_dout, 8'h5A);
    step(1'b0, 1'b1, 8'h00);
    chk("c.pop2.empty", c_empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
